// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ready handshake
// and feeds the IF/ID register, emitting all-zero bubbles when nothing is valid.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DISCARD,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] stale_q, stale_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            stale_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_FETCH: begin
                if (Branch_taken) begin
                    pc_d = Branch_address;
                    // A busy request must drain before the new target is issued.
                    if (!imem_ready) begin
                        stale_d = pc_q;
                        state_d = S_DISCARD;
                    end
                end else if (imem_ready) begin
                    if (Freeze) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            S_DISCARD: begin
                if (Branch_taken) pc_d = Branch_address;
                if (imem_ready)   state_d = S_FETCH;
            end
            S_HOLD: begin
                if (Branch_taken) begin
                    pc_d    = Branch_address;
                    state_d = S_FETCH;
                end else if (!Freeze) begin
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        valid       = 1'b0;
        instruction = '0;
        PC          = '0;
        if (rst) begin
            imem_addr = RESET_PC;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready && !Branch_taken && !Freeze) begin
                        valid       = 1'b1;
                        instruction = imem_rdata;
                        PC          = pc_plus4;
                    end
                end
                S_DISCARD: begin
                    imem_req  = 1'b1;
                    imem_addr = stale_q;
                end
                S_HOLD: begin
                    if (!Branch_taken) begin
                        valid       = 1'b1;
                        instruction = hold_q;
                        PC          = pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, Freeze, Branch_taken, imem_ready;
    logic [31:0] Branch_address, imem_rdata;
    logic        imem_req, valid;
    logic [31:0] imem_addr, PC, instruction;

    int unsigned checks = 0;
    int unsigned errors = 0;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .Freeze(Freeze), .Branch_taken(Branch_taken),
        .Branch_address(Branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC(PC),
        .instruction(instruction), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fr, br;
        logic [31:0] ba;
        logic        rdy;
        logic [31:0] rd;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] ei, epc;
    } vec_t;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hE5A0_0000;
    endfunction

    function automatic vec_t mk(input logic r, f, b, input logic [31:0] ba, input logic rdy,
                                input logic [31:0] rd, input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] ei, epc);
        vec_t v;
        v.rst = r; v.fr = f; v.br = b; v.ba = ba; v.rdy = rdy; v.rd = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.ei = ei; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        rst = v.rst; Freeze = v.fr; Branch_taken = v.br; Branch_address = v.ba;
        imem_ready = v.rdy; imem_rdata = v.rd;
        #1;
        chk({nm, ".req"}, {31'b0, imem_req}, {31'b0, v.ereq});
        if (v.ereq || v.rst) chk({nm, ".addr"}, imem_addr, v.eaddr);
        chk({nm, ".valid"}, {31'b0, valid}, {31'b0, v.ev});
        chk({nm, ".instr"}, instruction, v.ei);
        chk({nm, ".pc"}, PC, v.epc);
    endtask

    // Reference model: PC of the next fetch, an optional wrong-path request
    // still in flight, and a queue of instructions captured under Freeze.
    logic [31:0] m_pc, m_wrong_addr;
    bit          m_wrong;
    logic [31:0] m_held[$];
    int unsigned waited, target;

    initial begin
        vec_t tbl[$];
        logic e_req, e_v;
        logic [31:0] e_addr, e_i, e_pc;

        rst = 1'b1; Freeze = 1'b0; Branch_taken = 1'b0; Branch_address = '0;
        imem_ready = 1'b0; imem_rdata = '0;

        // reset, zero-wait, freeze on I@8, 2-wait, branch over a 3-wait request, branch+freeze in HOLD
        tbl.push_back(mk(1,0,0,0,0,0,            0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,            0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,tag(0),       1,0,1,tag(0),4));
        tbl.push_back(mk(0,0,0,0,1,tag(4),       1,4,1,tag(4),8));
        tbl.push_back(mk(0,1,0,0,1,tag(8),       1,8,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,            0,0,1,tag(8),12));
        tbl.push_back(mk(0,1,0,0,0,0,            0,0,1,tag(8),12));
        tbl.push_back(mk(0,0,0,0,0,0,            0,0,1,tag(8),12));
        tbl.push_back(mk(0,0,0,0,1,tag(12),      1,12,1,tag(12),16));
        tbl.push_back(mk(0,0,0,0,0,0,            1,16,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,            1,16,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,tag(16),      1,16,1,tag(16),20));
        tbl.push_back(mk(0,0,0,0,1,tag(20),      1,20,1,tag(20),24));
        tbl.push_back(mk(0,0,0,0,1,tag(24),      1,24,1,tag(24),28));
        tbl.push_back(mk(0,0,0,0,1,tag(28),      1,28,1,tag(28),32));
        tbl.push_back(mk(0,0,0,0,0,0,            1,32'h20,0,0,0));
        tbl.push_back(mk(0,0,1,32'h100,0,0,      1,32'h20,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,            1,32'h20,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,tag(32'h20),  1,32'h20,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,tag(32'h100), 1,32'h100,1,tag(32'h100),32'h104));
        tbl.push_back(mk(0,1,0,0,1,tag(32'h104), 1,32'h104,0,0,0));
        tbl.push_back(mk(0,1,1,32'h200,0,0,      0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,tag(32'h200), 1,32'h200,1,tag(32'h200),32'h204));
        tbl.push_back(mk(0,0,1,32'h300,1,tag(32'h204), 1,32'h204,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,tag(32'h300), 1,32'h300,1,tag(32'h300),32'h304));
        for (int unsigned i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // reset during DISCARD abandons the wrong-path request
        apply(mk(0,0,1,32'h400,0,0,    1,32'h304,0,0,0), "rstdisc.br");
        apply(mk(1,0,0,0,0,0,          0,RST_PC,0,0,0), "rstdisc.rst");
        apply(mk(0,0,0,0,1,tag(0),     1,RST_PC,1,tag(0),4), "rstdisc.first");

        // PC wrap at the top of the address space
        apply(mk(0,0,1,32'hFFFF_FFFC,1,tag(4), 1,4,0,0,0), "wrap.br");
        apply(mk(0,0,0,0,1,tag(32'hFFFF_FFFC), 1,32'hFFFF_FFFC,1,tag(32'hFFFF_FFFC),0), "wrap.top");
        apply(mk(0,0,0,0,1,tag(0),     1,0,1,tag(0),4), "wrap.zero");

        // randomized traffic with a variable-latency memory
        waited = 0; target = 0; m_wrong = 0; m_pc = RST_PC; m_wrong_addr = '0;
        for (int unsigned i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst            = (i < 2) || ($urandom_range(0, 199) == 0);
            Freeze         = ($urandom_range(0, 3) == 0);
            Branch_taken   = ($urandom_range(0, 11) == 0);
            Branch_address = $urandom & 32'hFFFF_FFFC;
            imem_ready     = !rst && imem_req && (waited >= target);
            imem_rdata     = imem_ready ? tag(imem_addr) : $urandom;
            #1;
            e_req = 0; e_addr = RST_PC; e_v = 0; e_i = '0; e_pc = '0;
            if (rst) begin
                m_pc = RST_PC; m_held.delete(); m_wrong = 0;
            end else if (m_held.size() > 0) begin
                if (Branch_taken) begin
                    m_held.delete(); m_pc = Branch_address;
                end else begin
                    e_v = 1; e_i = m_held[0]; e_pc = m_pc + 32'd4;
                    if (!Freeze) begin m_held.delete(); m_pc = m_pc + 32'd4; end
                end
            end else if (m_wrong) begin
                e_req = 1; e_addr = m_wrong_addr;
                if (Branch_taken) m_pc = Branch_address;
                if (imem_ready) m_wrong = 0;
            end else begin
                e_req = 1; e_addr = m_pc;
                if (Branch_taken) begin
                    if (!imem_ready) begin m_wrong = 1; m_wrong_addr = m_pc; end
                    m_pc = Branch_address;
                end else if (imem_ready) begin
                    if (Freeze) m_held.push_back(imem_rdata);
                    else begin e_v = 1; e_i = imem_rdata; e_pc = m_pc + 32'd4; m_pc = m_pc + 32'd4; end
                end
            end
            chk($sformatf("rnd%0d.req", i), {31'b0, imem_req}, {31'b0, e_req});
            if (e_req || rst) chk($sformatf("rnd%0d.addr", i), imem_addr, e_addr);
            chk($sformatf("rnd%0d.valid", i), {31'b0, valid}, {31'b0, e_v});
            chk($sformatf("rnd%0d.instr", i), instruction, e_i);
            chk($sformatf("rnd%0d.pc", i), PC, e_pc);
            if (rst) waited = 0;
            else if (imem_req) begin
                if (imem_ready) begin waited = 0; target = $urandom_range(0, 3); end
                else waited++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
